acc_sched: RTL and testbench
============================

Name: acc_sched

Overview:
- Shares one signed fixed-point accumulate datapath (the packed signed acc_t) between N_REQ requesters. Each requester has its own accumulation context.
- Requesters stream samples over valid/ready. A round-robin arbiter grants one beat per cycle into a 2-stage accumulate pipeline.
- On a requester's last beat, its total leaves through a single-entry result port, and its context is cleared.
- Sits between sample producers (filters, sensor front-ends) and a single consumer of accumulated results.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ITG_W, 8, integer bits of acc_t, signed.
- FRAC_W, 8, fraction bits of acc_t.
- CNT_W, 16, width of the per-context beat counter (saturating).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester sample valid
- req_data  in  N_REQ*W (W=ITG_W+FRAC_W)  flattened samples; requester k occupies bits [k*W +: W]; signed two's complement fixed-point
- req_last  in  N_REQ  qualifies the beat as the final one of requester k's frame
- req_ready  out  N_REQ  one-hot or zero; the beat transfers when valid&ready
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_id  out  $clog2(N_REQ)  requester that owns the result
- res_acc  out  W  accumulated total, saturated
- res_cnt  out  CNT_W  number of beats in the frame, including the last
- res_sat  out  1  sticky flag: saturation occurred somewhere in the frame
- busy  out  1  a stage-1 beat is in flight, or res_valid is high

Behaviour:
- Reset (async assert, sync deassert):
  - all contexts cleared to '{default:0}
  - RR pointer = 0
  - stage register invalid
  - res_valid=0; res_id, res_acc, res_cnt, res_sat = 0
  - req_ready=0; busy=0
- Eligibility of requester k: req_valid[k], AND if req_last[k] then (res_valid==0 AND the stage register does not hold a last beat).
- Arbitration:
  - round-robin among eligible requesters, starting at the RR pointer
  - req_ready[k]=1 only for the winner; combinational from inputs and state
  - after a grant to k, the pointer becomes (k+1) mod N_REQ; with no grant the pointer holds
- Stage 1 (cycle t): capture id, data and last into the stage register.
- Stage 2 (cycle t+1): sum = ctx[id].acc + data, computed at W+1 bits.
  - sum > +max → +max (0111..1), set sat
  - sum < -max-1 → min (1000..0), set sat
  - cnt increments and saturates at all-ones
- Context write, end of t+1:
  - not last: ctx[id] = {sum, cnt+1, sat_old|sat_new}
  - last: result register loaded with the same values, res_valid=1 at t+2, and ctx[id] cleared to '{default:0}
- Hazard: if stage 2 writes context k while stage 1 grants k again (back-to-back beats), stage 2 uses the forwarded value. No bubbles; one beat per cycle sustained for the same requester.
- Result handshake:
  - result held stable while res_valid && !res_ready
  - cleared on res_valid && res_ready
  - the eligibility rule guarantees the result register is never overwritten
- Last-beat throughput: at most one last beat per 2 cycles. Non-last beats from any requester are never blocked by a pending result.
- Reset mid-frame discards all partial contexts and any pending result. No result is emitted.
- Simultaneous events: a stage-2 last write for k and a new non-last grant for k in the same cycle → the new beat sees a cleared context (forward zero).

Decomposition:
- acc_sched_pkg holds:
  - typedef acc_t: struct packed signed {logic [ITG_W-1:0] itg; logic [FRAC_W-1:0] frac;}
  - typedef ctx_t: struct {acc_t acc; cnt; sat}
  - ACC_MAX and ACC_MIN constants
  - sat_add function
- One sub-module: acc_rr_arb (N-way round-robin arbiter: eligible vector and pointer in, one-hot grant and index out).

Test Plan:
- Reset: hold rst_n=0 while every req_valid=1 → req_ready=0, res_valid=0, busy=0. Release rst_n → first grant goes to requester 0.
- Single frame, req 2: beats 0x0180 (1.5), 0x0240 (2.25), 0xFF40 (-0.75, last) on consecutive cycles → res_valid 2 cycles after the last beat, res_id=2, res_acc=0x0300, res_cnt=3, res_sat=0.
- Fairness: all 4 requesters valid continuously, non-last → grant order 0,1,2,3,0,1... One grant per cycle, no requester starved.
- Saturation: req 1 sends 0x7F00 then 0x0100 (last) → res_acc=0x7FFF, res_sat=1. A following frame starting with 0x0100 (last) gives res_acc=0x0100, res_sat=0.
- Backpressure: res_ready=0 while req 0 and req 3 both present last beats → only one last beat accepted, and the result stays stable for 10 cycles. The other requester's req_ready stays 0 until the cycle after res_ready=1.
- Reset mid-frame: req 0 sends 2 non-last beats, then rst_n pulses low asynchronously → after release, a last beat of 0x0010 gives res_acc=0x0010, res_cnt=1.

Source files
------------

// File: rtl/acc_sched_pkg.sv
// Shared types, widths and the saturating add for the accumulate scheduler.
// acc_t depends on the widths, so they are fixed here rather than per instance.
package acc_sched_pkg;

    localparam int ITG_W  = 8;
    localparam int FRAC_W = 8;
    localparam int ACC_W  = ITG_W + FRAC_W;
    localparam int CNT_W  = 16;

    typedef struct packed signed {
        logic [ITG_W-1:0]  itg;
        logic [FRAC_W-1:0] frac;
    } acc_t;

    typedef struct packed {
        acc_t             acc;
        logic [CNT_W-1:0] cnt;
        logic             sat;
    } ctx_t;

    typedef struct packed {
        acc_t sum;
        logic sat;
    } add_t;

    localparam acc_t ACC_MAX = acc_t'({1'b0, {(ACC_W-1){1'b1}}});
    localparam acc_t ACC_MIN = acc_t'({1'b1, {(ACC_W-1){1'b0}}});

    // One guard bit is enough: overflow shows as the two top bits disagreeing.
    function automatic add_t sat_add(input acc_t a, input acc_t b);
        logic signed [ACC_W:0] s;
        add_t r;
        s = $signed({a[ACC_W-1], a}) + $signed({b[ACC_W-1], b});
        r.sat = s[ACC_W] ^ s[ACC_W-1];
        if (r.sat)
            r.sum = s[ACC_W] ? ACC_MIN : ACC_MAX;
        else
            r.sum = acc_t'(s[ACC_W-1:0]);
        return r;
    endfunction

endpackage

// File: rtl/acc_rr_arb.sv
// N-way round-robin arbiter: the first eligible requester at or after ptr wins.
module acc_rr_arb
    import acc_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int k;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!any && elig[k]) begin
                grant[k] = 1'b1;
                idx      = IW'(k);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/acc_sched.sv
// Shares one saturating accumulate datapath between N_REQ streaming requesters,
// each with its own context; completed frames leave through a one-entry result port.
module acc_sched
    import acc_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*ACC_W-1:0]   req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ID_W-1:0]          res_id,
    output logic [ACC_W-1:0]         res_acc,
    output logic [CNT_W-1:0]         res_cnt,
    output logic                     res_sat,
    output logic                     busy
);

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  ptr;
    logic             any;

    logic             vld_p1;
    logic             last_p1;
    logic [ID_W-1:0]  id_p1;
    acc_t             data_p1;

    ctx_t             ctx [N_REQ];
    ctx_t             cur_p2;
    ctx_t             upd_p2;
    add_t             add_p2;

    // A last beat may only enter when neither the result register nor stage 1
    // already owns a completed frame, so the result can never be overwritten.
    always_comb begin
        elig = '0;
        for (int k = 0; k < N_REQ; k++)
            elig[k] = req_valid[k] & (~req_last[k] | (~res_valid & ~(vld_p1 & last_p1)));
    end

    acc_rr_arb #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_arb (
        .elig  (elig),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win),
        .any   (any)
    );

    assign req_ready = grant & {N_REQ{rst_n}};
    assign busy      = vld_p1 | res_valid;

    // ---- stage 1: capture the granted beat ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            id_p1   <= '0;
            ptr     <= '0;
        end else begin
            vld_p1  <= any;
            last_p1 <= any & req_last[win];
            id_p1   <= win;
            if (any)
                ptr <= (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (any)
            data_p1 <= req_data[int'(win)*ACC_W +: ACC_W];
    end

    // ---- stage 2: accumulate into the owner's context ----
    // Context is read here, one cycle after the grant, so a back-to-back beat
    // for the same requester already sees the previous write (or the clear).
    always_comb begin
        cur_p2     = ctx[id_p1];
        add_p2     = sat_add(cur_p2.acc, data_p1);
        upd_p2.acc = add_p2.sum;
        upd_p2.cnt = (&cur_p2.cnt) ? cur_p2.cnt : cur_p2.cnt + 1'b1;
        upd_p2.sat = cur_p2.sat | add_p2.sat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_REQ; k++)
                ctx[k] <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_acc   <= '0;
            res_cnt   <= '0;
            res_sat   <= 1'b0;
        end else begin
            if (res_valid && res_ready)
                res_valid <= 1'b0;
            if (vld_p1) begin
                if (last_p1) begin
                    ctx[id_p1] <= '0;
                    res_valid  <= 1'b1;
                    res_id     <= id_p1;
                    res_acc    <= upd_p2.acc;
                    res_cnt    <= upd_p2.cnt;
                    res_sat    <= upd_p2.sat;
                end else begin
                    ctx[id_p1] <= upd_p2;
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_sched.sv
// Directed and randomized stimulus for acc_sched, checked cycle by cycle against
// a frame-level model (integer sums with clamping, result queue, round-robin rule).
module tb_acc_sched;
    import acc_sched_pkg::*;

    localparam int N    = 4;
    localparam int W    = ACC_W;
    localparam int AMAX = (1 << (W - 1)) - 1;
    localparam int AMIN = -(1 << (W - 1));
    localparam int CMAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_last = '0;
    logic [N*W-1:0]   req_data = '0;
    logic [N-1:0]     req_ready;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [1:0]       res_id;
    logic [W-1:0]     res_acc;
    logic [CNT_W-1:0] res_cnt;
    logic             res_sat;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acc_sched #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_acc   (res_acc),
        .res_cnt   (res_cnt),
        .res_sat   (res_sat),
        .busy      (busy)
    );

    typedef struct {
        int id;
        int acc;
        int cnt;
        bit sat;
    } res_s;

    res_s exp_q[$];
    int   m_acc [N];
    int   m_cnt [N];
    bit   m_sat [N];
    int   m_ptr;
    bit   m_pend;
    bit   m_stage;
    bit   m_stage_last;

    int               win;
    logic [N-1:0]     obs_rdy;
    logic             obs_rv;
    logic [1:0]       obs_id;
    logic [W-1:0]     obs_acc;
    logic [CNT_W-1:0] obs_cnt;
    logic             obs_sat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_acc[k] = 0;
            m_cnt[k] = 0;
            m_sat[k] = 1'b0;
        end
        m_ptr        = 0;
        m_pend       = 1'b0;
        m_stage      = 1'b0;
        m_stage_last = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_beat(input int k, input int d, input bit last);
        int s;
        s = m_acc[k] + d;
        if (s > AMAX) begin
            s = AMAX;
            m_sat[k] = 1'b1;
        end else if (s < AMIN) begin
            s = AMIN;
            m_sat[k] = 1'b1;
        end
        m_acc[k] = s;
        if (m_cnt[k] < CMAX)
            m_cnt[k]++;
        if (last) begin
            exp_q.push_back('{k, s, m_cnt[k], m_sat[k]});
            m_acc[k] = 0;
            m_cnt[k] = 0;
            m_sat[k] = 1'b0;
        end
    endtask

    // Observe one clock cycle at the falling edge, then advance the model.
    task automatic cycle();
        logic [N-1:0] elig;
        logic [N-1:0] exp_rdy;
        bit           nxt_pend;
        res_s         e;
        @(negedge clk);
        elig    = '0;
        exp_rdy = '0;
        win     = -1;
        for (int k = 0; k < N; k++)
            if (req_valid[k] && (!req_last[k] || (!m_pend && !m_stage_last)))
                elig[k] = 1'b1;
        for (int i = 0; i < N; i++)
            if (win < 0 && elig[(m_ptr + i) % N])
                win = (m_ptr + i) % N;
        if (win >= 0)
            exp_rdy[win] = 1'b1;
        obs_rdy = req_ready;
        obs_rv  = res_valid;
        obs_id  = res_id;
        obs_acc = res_acc;
        obs_cnt = res_cnt;
        obs_sat = res_sat;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("res_valid", 32'(res_valid), 32'(m_pend));
        chk("busy", 32'(busy), 32'(m_stage || m_pend));
        if (m_pend && res_valid) begin
            if (exp_q.size() == 0) begin
                chk("res_queue", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q[0];
                chk("res_id", 32'(res_id), 32'(e.id));
                chk("res_acc", 32'(res_acc), 32'(e.acc & 'hFFFF));
                chk("res_cnt", 32'(res_cnt), 32'(e.cnt));
                chk("res_sat", 32'(res_sat), 32'(e.sat));
                if (res_ready)
                    void'(exp_q.pop_front());
            end
        end
        nxt_pend     = (m_pend && !res_ready) || m_stage_last;
        m_stage      = (win >= 0);
        m_stage_last = (win >= 0) && req_last[win];
        if (win >= 0) begin
            model_beat(win, int'($signed(req_data[win*W +: W])), req_last[win]);
            m_ptr = (win + 1) % N;
        end
        m_pend = nxt_pend;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input int max, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!obs_rv && n < max);
        chk("result_timeout", 32'(obs_rv), 32'd1);
    endtask

    task automatic drive(input int k, input logic [W-1:0] d, input bit last);
        req_valid = '0;
        req_last  = '0;
        req_valid[k] = 1'b1;
        req_last[k]  = last;
        req_data[k*W +: W] = d;
    endtask

    task automatic idle();
        req_valid = '0;
        req_last  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w;
        int o;
        logic [W-1:0] held;

        // Reset with every requester asking
        model_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        req_last  = '0;
        req_data  = {$urandom, $urandom};
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_acc", 32'(res_acc), 32'd0);
        chk("rst_res_cnt", 32'(res_cnt), 32'd0);
        rst_n = 1'b1;

        // Fairness: first grant to 0, then strict rotation
        for (int i = 0; i < 8; i++) begin
            req_data = {$urandom, $urandom};
            cycle();
            chk("rr_order", 32'(obs_rdy), 32'(1 << (i % N)));
        end

        // Close every open frame with a last beat
        req_last = '1;
        for (int i = 0; i < 40 && req_valid != 0; i++) begin
            cycle();
            if (win >= 0)
                req_valid[win] = 1'b0;
        end
        chk("close_all", 32'(req_valid), 32'd0);
        idle();
        repeat (3) cycle();

        // Single frame on requester 2, one beat per cycle
        drive(2, 16'h0180, 1'b0); cycle(); chk("f_beat0", 32'(obs_rdy), 32'h4);
        drive(2, 16'h0240, 1'b0); cycle(); chk("f_beat1", 32'(obs_rdy), 32'h4);
        drive(2, 16'hFF40, 1'b1); cycle(); chk("f_beat2", 32'(obs_rdy), 32'h4);
        idle();
        wait_result(8, n);
        chk("f_latency", 32'(n), 32'd2);
        chk("f_id", 32'(obs_id), 32'd2);
        chk("f_acc", 32'(obs_acc), 32'h0300);
        chk("f_cnt", 32'(obs_cnt), 32'd3);
        chk("f_sat", 32'(obs_sat), 32'd0);

        // Positive saturation, then a clean frame on the same requester
        drive(1, 16'h7F00, 1'b0); cycle();
        drive(1, 16'h0100, 1'b1); cycle();
        idle();
        wait_result(8, n);
        chk("sat_acc", 32'(obs_acc), 32'h7FFF);
        chk("sat_flag", 32'(obs_sat), 32'd1);
        chk("sat_cnt", 32'(obs_cnt), 32'd2);
        drive(1, 16'h0100, 1'b1); cycle();
        chk("sat2_grant", 32'(obs_rdy), 32'h2);
        idle();
        wait_result(8, n);
        chk("sat2_acc", 32'(obs_acc), 32'h0100);
        chk("sat2_flag", 32'(obs_sat), 32'd0);
        chk("sat2_cnt", 32'(obs_cnt), 32'd1);

        // Backpressure: two competing last beats, result held
        res_ready = 1'b0;
        req_valid = 4'b1001;
        req_last  = 4'b1001;
        req_data  = {$urandom, $urandom};
        cycle();
        chk("bp_single", 32'($countones(obs_rdy)), 32'd1);
        w = win;
        o = (w == 0) ? 3 : 0;
        req_valid[w] = 1'b0;
        cycle();
        cycle();
        held = obs_acc;
        chk("bp_valid", 32'(obs_rv), 32'd1);
        req_valid[1] = 1'b1;
        req_last[1]  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5)
                req_valid[1] = 1'b0;
            cycle();
            chk("bp_hold_acc", 32'(obs_acc), 32'(held));
            chk("bp_blocked", 32'(obs_rdy[o]), 32'd0);
            if (i < 5)
                chk("bp_nonlast_flows", 32'(obs_rdy[1]), 32'd1);
        end
        res_ready = 1'b1;
        cycle();
        chk("bp_still_blocked", 32'(obs_rdy[o]), 32'd0);
        cycle();
        chk("bp_release", 32'(obs_rdy[o]), 32'd1);
        idle();
        wait_result(8, n);
        repeat (2) cycle();

        // Asynchronous reset in the middle of a frame
        drive(0, 16'(($urandom & 16'h0FFF)), 1'b0); cycle();
        drive(0, 16'(($urandom & 16'h0FFF)), 1'b0); cycle();
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 16'h0010, 1'b1); cycle();
        idle();
        wait_result(8, n);
        chk("mid_rst_acc", 32'(obs_acc), 32'h0010);
        chk("mid_rst_cnt", 32'(obs_cnt), 32'd1);

        // Randomized traffic with random consumer stalls
        for (int i = 0; i < 400; i++) begin
            req_valid = 4'($urandom);
            req_last  = 4'($urandom) & 4'($urandom);
            req_data  = {$urandom, $urandom};
            res_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        idle();
        res_ready = 1'b1;
        repeat (4) cycle();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
